// File: rtl/neo_sequencer_if.sv
// Sample-memory / NEO result bus between neo_sequencer and its neighbours.
// THRESH_EN adds the thresh input and spike output.
interface neo_sequencer_if #(
    parameter int N = 16,
    parameter int M = 16
);
    localparam int AW = $clog2(M) + 1;

    logic                  start;
    logic signed [N-1:0]   rdata;
    logic [AW-1:0]         raddr;
    logic                  busy;
    logic                  done;
    logic                  neo_valid;
    logic [AW-1:0]         neo_idx;
    logic signed [2*N-1:0] neo_out;
`ifdef THRESH_EN
    logic signed [2*N-1:0] thresh;
    logic                  spike;
`endif

    modport slave (
        input  start, rdata,
`ifdef THRESH_EN
        input  thresh,
        output spike,
`endif
        output raddr, busy, done, neo_valid, neo_idx, neo_out
    );

    modport master (
        output start, rdata,
`ifdef THRESH_EN
        output thresh,
        input  spike,
`endif
        input  raddr, busy, done, neo_valid, neo_idx, neo_out
    );
endinterface

// File: rtl/neo_sequencer.sv
// Streams memory 0..M-1 through a 3-sample window, emitting Teager/Kaiser NEO.
// THRESH_EN adds a registered spike flag (neo_out > thresh).
module neo_sequencer #(
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic           Clk,
    input  logic           reset,
    neo_sequencer_if.slave bus
);
    localparam int AW = $clog2(M) + 1;
    localparam logic [AW-1:0] LAST = AW'(M - 1);

    generate
        if (M < 3) begin : g_bad_m
            $error("neo_sequencer: M must be >= 3");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic                  vld;
    logic [AW-1:0]         beats;
    logic signed [N-1:0]   x_prev;
    logic signed [N-1:0]   x_cur;
    logic signed [2*N-1:0] wp;
    logic signed [2*N-1:0] wc;
    logic signed [2*N-1:0] wn;
    logic signed [2*N-1:0] psi;
    logic                  compute;

    // Sign-extend to 2N first so both products are full precision.
    assign wp      = {{N{x_prev[N-1]}}, x_prev};
    assign wc      = {{N{x_cur[N-1]}}, x_cur};
    assign wn      = {{N{bus.rdata[N-1]}}, bus.rdata};
    assign psi     = (wc * wc) - (wp * wn);
    assign compute = vld && (beats >= AW'(2));

    always_ff @(posedge Clk) begin
        if (reset) begin
            state         <= IDLE;
            vld           <= 1'b0;
            beats         <= '0;
            x_prev        <= '0;
            x_cur         <= '0;
            bus.raddr     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.neo_valid <= 1'b0;
            bus.neo_idx   <= '0;
            bus.neo_out   <= '0;
`ifdef THRESH_EN
            bus.spike     <= 1'b0;
`endif
        end else begin
            vld           <= (state == RUN);
            bus.done      <= 1'b0;
            bus.neo_valid <= 1'b0;
`ifdef THRESH_EN
            bus.spike     <= 1'b0;
`endif
            if (vld) begin
                x_prev <= x_cur;
                x_cur  <= bus.rdata;
                beats  <= beats + 1'b1;
            end
            if (compute) begin
                bus.neo_valid <= 1'b1;
                bus.neo_out   <= psi;
                bus.neo_idx   <= beats - 1'b1;
`ifdef THRESH_EN
                bus.spike     <= (psi > bus.thresh);
`endif
            end
            unique case (state)
                IDLE: begin
                    bus.raddr <= '0;
                    if (bus.start) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        beats    <= '0;
                    end
                end
                RUN: begin
                    if (bus.raddr == LAST) begin
                        state     <= DRAIN;
                        bus.raddr <= '0;
                    end else begin
                        bus.raddr <= bus.raddr + 1'b1;
                    end
                end
                // Last beat is in flight while vld is still high.
                DRAIN: begin
                    if (!vld) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
